// File: rtl/axi_ic_pkg.sv
// Shared AXI interconnect constants and types.
package axi_ic_pkg;

  localparam int unsigned ID_W      = 8;
  localparam int unsigned ROB_DEPTH = 4;
  localparam logic [ID_W-1:0] ROB_EMPTY_ID = 8'hFF;

  typedef logic [2:0] rob_cnt_t;

endpackage

// File: rtl/rob_first_match.sv
// Oldest-first priority select: one-hot of the lowest set match bit, plus hit.
module rob_first_match #(
  parameter int unsigned DEPTH = 4
) (
  input  logic [DEPTH-1:0] match,
  output logic [DEPTH-1:0] onehot,
  output logic             hit
);

  logic found;

  always_comb begin
    onehot = '0;
    found  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (match[i] && !found) begin
        onehot[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign hit = |match;

endmodule

// File: rtl/rob_id_tracker.sv
// In-order ARID tracker: appends on AR accept, retires oldest matching ID on
// RLAST and compacts younger entries toward slot 0.
module rob_id_tracker #(
  parameter int unsigned     ID_W     = axi_ic_pkg::ID_W,
  parameter int unsigned     DEPTH    = axi_ic_pkg::ROB_DEPTH,
  parameter logic [ID_W-1:0] EMPTY_ID = axi_ic_pkg::ROB_EMPTY_ID
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ar_push,
  input  logic [ID_W-1:0]      ar_id,
  input  logic                 r_pop,
  input  logic [ID_W-1:0]      r_id,
  output logic [ID_W-1:0]      rob_buffer [0:DEPTH-1],
  output logic [DEPTH-1:0]     rob_vld,
  output axi_ic_pkg::rob_cnt_t rob_cnt,
  output logic                 rob_full,
  output logic                 rob_empty,
  output logic                 err_ovf,
  output logic                 err_unmatched
);

  import axi_ic_pkg::*;

  localparam rob_cnt_t DEPTH_CNT = rob_cnt_t'(DEPTH);

  logic [DEPTH-1:0] match;
  logic [DEPTH-1:0] onehot;
  logic             hit;
  logic [DEPTH-1:0] shift_mask;
  logic             acc;

  logic [ID_W-1:0]  buf_n [0:DEPTH-1];
  logic [DEPTH-1:0] vld_n;
  rob_cnt_t         cnt_pop;
  rob_cnt_t         cnt_n;
  logic             ovf_n;
  logic             unm_n;

  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = r_pop && rob_vld[i] && (rob_buffer[i] == r_id);
    end
  end

  rob_first_match #(.DEPTH(DEPTH)) u_first_match (
    .match  (match),
    .onehot (onehot),
    .hit    (hit)
  );

  // Pop compaction first, then the push lands at the post-pop tail.
  always_comb begin
    buf_n      = rob_buffer;
    vld_n      = rob_vld;
    cnt_pop    = rob_cnt;
    cnt_n      = rob_cnt;
    ovf_n      = err_ovf;
    unm_n      = err_unmatched;
    acc        = 1'b0;
    shift_mask = '0;

    for (int i = 0; i < DEPTH; i++) begin
      acc           = acc | onehot[i];
      shift_mask[i] = acc;
    end

    for (int i = 0; i < DEPTH - 1; i++) begin
      if (shift_mask[i]) begin
        buf_n[i] = rob_buffer[i+1];
        vld_n[i] = rob_vld[i+1];
      end
    end
    if (shift_mask[DEPTH-1]) begin
      buf_n[DEPTH-1] = EMPTY_ID;
      vld_n[DEPTH-1] = 1'b0;
    end

    if (hit) begin
      cnt_pop = rob_cnt - rob_cnt_t'(1);
    end
    if (r_pop && !hit) begin
      unm_n = 1'b1;
    end
    cnt_n = cnt_pop;

    if (ar_push) begin
      if (cnt_pop == DEPTH_CNT) begin
        ovf_n = 1'b1;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (cnt_pop == rob_cnt_t'(i)) begin
            buf_n[i] = ar_id;
            vld_n[i] = 1'b1;
          end
        end
        cnt_n = cnt_pop + rob_cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        rob_buffer[i] <= EMPTY_ID;
      end
      rob_vld       <= '0;
      rob_cnt       <= '0;
      err_ovf       <= 1'b0;
      err_unmatched <= 1'b0;
    end else begin
      rob_buffer    <= buf_n;
      rob_vld       <= vld_n;
      rob_cnt       <= cnt_n;
      err_ovf       <= ovf_n;
      err_unmatched <= unm_n;
    end
  end

  assign rob_full  = (rob_cnt == DEPTH_CNT);
  assign rob_empty = (rob_cnt == rob_cnt_t'(0));

endmodule

// File: tb/tb_rob_id_tracker.sv
// Directed bench for rob_id_tracker with hand-computed expectations.
module tb_rob_id_tracker;

  logic       clk;
  logic       rst;
  logic       ar_push;
  logic [7:0] ar_id;
  logic       r_pop;
  logic [7:0] r_id;
  logic [7:0] rob_buffer [0:3];
  logic [3:0] rob_vld;
  logic [2:0] rob_cnt;
  logic       rob_full;
  logic       rob_empty;
  logic       err_ovf;
  logic       err_unmatched;

  int checks = 0;
  int errors = 0;

  rob_id_tracker dut (
    .clk           (clk),
    .rst           (rst),
    .ar_push       (ar_push),
    .ar_id         (ar_id),
    .r_pop         (r_pop),
    .r_id          (r_id),
    .rob_buffer    (rob_buffer),
    .rob_vld       (rob_vld),
    .rob_cnt       (rob_cnt),
    .rob_full      (rob_full),
    .rob_empty     (rob_empty),
    .err_ovf       (err_ovf),
    .err_unmatched (err_unmatched)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_buf(input string tag, input logic [31:0] exp);
    chk(tag, {rob_buffer[0], rob_buffer[1], rob_buffer[2], rob_buffer[3]}, exp);
  endtask

  task automatic cyc(input logic push, input logic [7:0] aid,
                     input logic pop, input logic [7:0] rid);
    ar_push = push;
    ar_id   = aid;
    r_pop   = pop;
    r_id    = rid;
    @(posedge clk);
    #1;
    ar_push = 1'b0;
    r_pop   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ar_push = 1'b0; ar_id = 8'h00; r_pop = 1'b0; r_id = 8'h00;
    cyc(1'b0, 8'h00, 1'b0, 8'h00);
    cyc(1'b0, 8'h00, 1'b0, 8'h00);
    rst = 1'b0;

    chk_buf("reset_buf", 32'hFFFF_FFFF);
    chk("reset_vld", rob_vld, 4'b0000);
    chk("reset_cnt", rob_cnt, 3'd0);
    chk("reset_empty", rob_empty, 1'b1);
    chk("reset_full", rob_full, 1'b0);
    chk("reset_errs", {err_ovf, err_unmatched}, 2'b00);

    cyc(1'b1, 8'h10, 1'b0, 8'h00);
    chk("one_push_cnt", rob_cnt, 3'd1);
    chk("one_push_empty", rob_empty, 1'b0);
    cyc(1'b1, 8'h21, 1'b0, 8'h00);
    cyc(1'b1, 8'h32, 1'b0, 8'h00);
    cyc(1'b1, 8'h43, 1'b0, 8'h00);
    chk_buf("fill_buf", 32'h1021_3243);
    chk("fill_vld", rob_vld, 4'b1111);
    chk("fill_cnt", rob_cnt, 3'd4);
    chk("fill_full", rob_full, 1'b1);

    cyc(1'b0, 8'h00, 1'b1, 8'h21);
    chk_buf("mid_pop_buf", 32'h1032_43FF);
    chk("mid_pop_vld", rob_vld, 4'b0111);
    chk("mid_pop_cnt", rob_cnt, 3'd3);
    chk("mid_pop_full", rob_full, 1'b0);

    cyc(1'b0, 8'h00, 1'b1, 8'h43);
    chk_buf("top_pop_buf", 32'h1032_FFFF);
    cyc(1'b0, 8'h00, 1'b1, 8'h32);
    cyc(1'b1, 8'h21, 1'b0, 8'h00);
    cyc(1'b1, 8'h21, 1'b0, 8'h00);
    chk_buf("dup_setup_buf", 32'h1021_21FF);
    cyc(1'b0, 8'h00, 1'b1, 8'h21);
    chk_buf("dup_pop_buf", 32'h1021_FFFF);
    chk("dup_pop_vld", rob_vld, 4'b0011);
    chk("dup_pop_cnt", rob_cnt, 3'd2);

    cyc(1'b1, 8'h32, 1'b0, 8'h00);
    cyc(1'b1, 8'h43, 1'b0, 8'h00);
    chk_buf("refill_buf", 32'h1021_3243);
    cyc(1'b1, 8'h54, 1'b1, 8'h10);
    chk_buf("full_pushpop_buf", 32'h2132_4354);
    chk("full_pushpop_cnt", rob_cnt, 3'd4);
    chk("full_pushpop_ovf", err_ovf, 1'b0);
    cyc(1'b1, 8'h65, 1'b0, 8'h00);
    chk_buf("ovf_buf", 32'h2132_4354);
    chk("ovf_cnt", rob_cnt, 3'd4);
    chk("ovf_flag", err_ovf, 1'b1);
    chk("ovf_unm", err_unmatched, 1'b0);

    rst = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, 8'h00);
    rst = 1'b0;
    chk("rst2_ovf", err_ovf, 1'b0);
    cyc(1'b1, 8'h10, 1'b0, 8'h00);
    cyc(1'b0, 8'h00, 1'b1, 8'h77);
    chk_buf("unm_buf", 32'h10FF_FFFF);
    chk("unm_cnt", rob_cnt, 3'd1);
    chk("unm_flag", err_unmatched, 1'b1);
    cyc(1'b1, 8'h21, 1'b1, 8'h10);
    chk_buf("pushpop_buf", 32'h21FF_FFFF);
    chk("unm_sticky", err_unmatched, 1'b1);
    cyc(1'b1, 8'h33, 1'b1, 8'h33);
    chk_buf("same_id_buf", 32'h2133_FFFF);
    chk("same_id_cnt", rob_cnt, 3'd2);
    cyc(1'b1, 8'h44, 1'b0, 8'h00);
    chk("three_cnt", rob_cnt, 3'd3);
    chk("unm_sticky2", err_unmatched, 1'b1);

    rst = 1'b1;
    cyc(1'b1, 8'h55, 1'b0, 8'h00);
    rst = 1'b0;
    chk_buf("rst3_buf", 32'hFFFF_FFFF);
    chk("rst3_vld", rob_vld, 4'b0000);
    chk("rst3_cnt", rob_cnt, 3'd0);
    chk("rst3_empty", rob_empty, 1'b1);
    chk("rst3_errs", {err_ovf, err_unmatched}, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rob_id_tracker.md
# rob_id_tracker

Read-reorder tracking stage of the AXI interconnect: records the ARID of every accepted read address in issue order and presents the outstanding IDs, oldest first, as `rob_buffer[0:3]` to the downstream `reorder` grant logic. When a read response's last beat is accepted for an ID, the tracker retires the oldest matching entry and compacts the younger entries toward slot 0. It also provides the full/empty back-pressure that gates AR issue.

## Interface
- `ID_W`, 8: ARID/RID width.
- `DEPTH`, 4: number of tracked outstanding reads; must equal the `rob_buffer` depth consumed by `reorder`.
- `EMPTY_ID`, `8'hFF`: fill value for unoccupied slots; reserved, masters never issue it.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `ar_push`  in  1  AR handshake accepted this cycle (`arvalid & arready` at the slave side).
- `ar_id`  in  ID_W  ARID of the accepted request.
- `r_pop`  in  1  R beat with `rlast` accepted this cycle.
- `r_id`  in  ID_W  RID of that last beat.
- `rob_buffer`  out  ID_W x DEPTH (unpacked `[0:DEPTH-1]`)  outstanding IDs; slot 0 oldest.
- `rob_vld`  out  DEPTH  per-slot occupancy; thermometer code from bit 0.
- `rob_cnt`  out  3  occupied slots, 0..4.
- `rob_full`  out  1  `rob_cnt == DEPTH`; combinational from `rob_cnt`; upstream drops `arready` while high.
- `rob_empty`  out  1  `rob_cnt == 0`.
- `err_ovf`  out  1  sticky: push accepted while full with no pop.
- `err_unmatched`  out  1  sticky: pop whose `r_id` matched no valid slot.

## Operation
- Storage: DEPTH registers of ID_W plus `rob_vld`; occupied slots always contiguous from slot 0.
- Pop: match vector = valid slots whose ID equals `r_id`; first-match (lowest index = oldest) slot k is retired; slots k+1..cnt-1 shift down by one; top occupied slot becomes `EMPTY_ID`, vld cleared. No match: no change, `err_unmatched` set.
- Push: `ar_id` written at slot `rob_cnt` (post-pop index when simultaneous), vld set.
- Simultaneous push+pop: pop compaction first, then push appended at `cnt-1` (matched pop) or `cnt` (unmatched pop); net `rob_cnt` unchanged on matched pop.
- Push while full: with a matched pop in the same cycle, legal (append at slot 3); without, push dropped, state unchanged, `err_ovf` set.
- Pop with same ID as a same-cycle push never retires the pushed entry (push not yet visible).
- Duplicate IDs allowed; only the oldest instance retired per pop.
- Error flags clear only on `rst`.

## Timing
- Reset (sync, `rst=1` at a clock edge): all slots `EMPTY_ID`, `rob_vld=0`, `rob_cnt=0`, `rob_empty=1`, `rob_full=0`, both error flags 0. Reset mid-operation discards all entries on that edge; push/pop in the reset cycle ignored.
- Latency: push/pop sampled at edge N; `rob_buffer`, `rob_vld`, `rob_cnt`, flags valid after edge N (one cycle). `reorder` then registers `order_grant` one cycle later: push-to-grant two cycles.
- All outputs registered except `rob_full`/`rob_empty` (decode of registered `rob_cnt`, no input path).
- No ready/valid of its own: `ar_push`/`r_pop` are single-cycle qualifiers, one event each per cycle.

## Structure
- Shared package `axi_ic_pkg`: `ID_W`, `ROB_DEPTH`, `ROB_EMPTY_ID`, `rob_cnt_t` (3-bit).
- One sub-module: `rob_first_match` — DEPTH-bit match vector in, one-hot oldest match plus `hit` out, purely combinational; the remaining logic (shift/compaction, counter, flags) stays in `rob_id_tracker`.

## Test plan
- Reset then push IDs 8'h10, 8'h21, 8'h32, 8'h43 on consecutive cycles -> `rob_buffer={10,21,32,43}`, `rob_cnt=4`, `rob_full=1` one cycle after last push.
- From full, pop `r_id=8'h21` -> `{10,32,43,FF}`, `rob_vld=4'b0111`, `rob_cnt=3`, `rob_full=0`.
- Buffer `{10,21,21,FF}`, pop 8'h21 -> `{10,21,FF,FF}` (oldest duplicate retired).
- Full `{10,21,32,43}`, same cycle push 8'h54 and pop 8'h10 -> `{21,32,43,54}`, `rob_cnt=4`, `err_ovf=0`; next cycle push 8'h65 alone -> buffer unchanged, `err_ovf=1`.
- Buffer `{10,FF,FF,FF}`, pop 8'h77 -> unchanged, `err_unmatched=1`; sticky through further traffic until `rst`.
- Three entries present, assert `rst` with simultaneous push -> all slots `FF`, `rob_cnt=0`, flags 0 next cycle.
